// File: rtl/event_rr_arbiter.sv
// event_rr_arbiter
//   Merges NUM_IN first-word-fall-through event FIFOs into one registered
//   valid/ready stream. It uses round-robin priority and pops at most one
//   FIFO per cycle, with no bubbles while the consumer keeps accepting.
//
//   Handshake: out_valid means the output register holds an event. The event
//   transfers on a clock edge where out_valid && out_ready. While out_valid is
//   high and out_ready is low, out_valid/out_data/out_src hold.
//
//   Optional feature macro: ARB_STATS_EN builds the saturating pop counter
//   behind stat_pops. Without it, stat_pops is tied to zero.
module event_rr_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SRC_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_empty,
  input  logic [NUM_IN*WIDTH-1:0] in_dout,
  output logic [NUM_IN-1:0]       in_rd_en,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic [15:0]             stat_pops
);

  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] scan_idx;
  logic             grant_found;
  logic             load;
  logic             pop;
  logic [WIDTH-1:0] sel_data;

  // The output stage can take a new event when it is empty or being drained this cycle.
  assign load = ~out_valid | out_ready;
  assign pop  = load & grant_found & ~rst;

  // Round-robin search: first non-empty input after last_grant, wrapping modulo NUM_IN.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      scan_idx = SRC_W'((int'(last_grant) + k) % NUM_IN);
      if (!grant_found && !in_empty[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Head-of-FIFO mux for the granted input.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SRC_W'(i)) sel_data = in_dout[i*WIDTH +: WIDTH];
    end
  end

  // One-hot pop strobe; a pop only happens together with a capture into the stage.
  always_comb begin
    in_rd_en = '0;
    if (pop) in_rd_en[grant_idx] = 1'b1;
  end

  // Output register and priority pointer; priority only rotates on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SRC_W'(NUM_IN - 1);
    end else if (load) begin
      if (grant_found) begin
        out_valid  <= 1'b1;
        out_data   <= sel_data;
        out_src    <= grant_idx;
        last_grant <= grant_idx;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] pop_cnt;

  // Saturating count of cycles that popped a FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt <= 16'h0000;
    end else if (|in_rd_en && (pop_cnt != 16'hFFFF)) begin
      pop_cnt <= pop_cnt + 16'd1;
    end
  end

  assign stat_pops = pop_cnt;
`else
  assign stat_pops = 16'h0000;
`endif

endmodule

// File: tb/tb_event_rr_arbiter.sv
// tb_event_rr_arbiter
//   Drives four modelled FWFT FIFOs into event_rr_arbiter. A vector table
//   with hand-derived grants covers reset, rotation, stall, priority and
//   reset-while-stalled. A random phase and a long counter run follow. The
//   reference round-robin model and the expected-event queue check every
//   cycle.
module tb_event_rr_arbiter;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int SRC_W  = 2;
`ifdef ARB_STATS_EN
  localparam int LONG_CYCLES = 70000;
  localparam logic [15:0] STAT_END = 16'hFFFF;
`else
  localparam int LONG_CYCLES = 100;
  localparam logic [15:0] STAT_END = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_IN-1:0]       in_empty = '1;
  logic [NUM_IN*WIDTH-1:0] in_dout = '0;
  logic [NUM_IN-1:0]       in_rd_en;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready = 1'b0;
  logic [15:0]             stat_pops;

  always #5 clk = ~clk;

  event_rr_arbiter #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SRC_W(SRC_W)) dut (
    .clk(clk), .rst(rst), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(in_rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .stat_pops(stat_pops)
  );

  // ---------------- model state / scoreboard ----------------
  logic [WIDTH-1:0]       fifo_q [NUM_IN][$];
  logic [SRC_W+WIDTH-1:0] exp_q[$];
  int   lg_m   = NUM_IN - 1;
  logic ov_m   = 1'b0;
  int   pops_m = 0;
  logic in_sync = 1'b0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic       rst;
    logic       ready;
    logic [3:0] fill;
    int         exp_g;   // -1: no pop expected, -2: not hand-checked
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic rdy, input logic [3:0] f, input int g);
    vec_t v;
    v.rst = r; v.ready = rdy; v.fill = f; v.exp_g = g;
    vecs.push_back(v);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic rst_v, input logic ready_v, input logic [3:0] fill, input int exp_g);
    int g_m;
    int idx;
    logic [NUM_IN-1:0] exp_rd;
    logic [15:0] exp_stat;
    for (int i = 0; i < NUM_IN; i++) begin
      if (fill[i]) fifo_q[i].push_back($urandom);
    end
    rst = rst_v;
    out_ready = ready_v;
    for (int i = 0; i < NUM_IN; i++) begin
      in_empty[i] = (fifo_q[i].size() == 0);
      in_dout[i*WIDTH +: WIDTH] = (fifo_q[i].size() == 0) ? '0 : fifo_q[i][0];
    end
    #1;
    // reference grant
    g_m = -1;
    if (!rst_v && (!ov_m || ready_v)) begin
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = (lg_m + k) % NUM_IN;
        if (g_m < 0 && fifo_q[idx].size() != 0) g_m = idx;
      end
    end
    exp_rd = (g_m >= 0) ? NUM_IN'(1 << g_m) : '0;
    check("rd_en", 64'(in_rd_en), 64'(exp_rd));
    if (exp_g != -2) check("grant", 64'(in_rd_en), (exp_g < 0) ? 64'd0 : 64'(1 << exp_g));
    if (in_sync) begin
      check("out_valid", 64'(out_valid), 64'(ov_m));
      exp_stat = (pops_m > 65535) ? 16'hFFFF : 16'(pops_m);
`ifndef ARB_STATS_EN
      exp_stat = 16'h0000;
`endif
      check("stat_pops", 64'(stat_pops), 64'(exp_stat));
      if (ov_m) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard: got out_valid=1 expected a queued event at %0t", $time);
        end else begin
          check("out_word", 64'({out_src, out_data}), 64'(exp_q[0]));
        end
      end
    end
    // model update at this edge
    if (rst_v) begin
      ov_m = 1'b0; lg_m = NUM_IN - 1; pops_m = 0;
      exp_q.delete();
    end else begin
      if (ov_m && ready_v && exp_q.size() != 0) void'(exp_q.pop_front());
      if (!ov_m || ready_v) begin
        if (g_m >= 0) begin
          exp_q.push_back({SRC_W'(g_m), fifo_q[g_m].pop_front()});
          ov_m = 1'b1; lg_m = g_m; pops_m++;
        end else begin
          ov_m = 1'b0;
        end
      end
    end
    @(posedge clk);
    if (rst_v) in_sync = 1'b1;
    @(negedge clk);
  endtask

  function automatic int total_words();
    int n = 0;
    for (int i = 0; i < NUM_IN; i++) n += fifo_q[i].size();
    return n;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    // reset with all FIFOs non-empty; fifo 0 gets a second word
    add_vec(1, 1, 4'b1111, -1);
    add_vec(1, 1, 4'b0001, -1);
    // full-throughput rotation with wrap 3 -> 0
    add_vec(0, 1, 4'b0000, 0);
    add_vec(0, 1, 4'b0000, 1);
    add_vec(0, 1, 4'b0000, 2);
    add_vec(0, 1, 4'b0000, 3);
    add_vec(0, 1, 4'b0000, 0);
    add_vec(0, 1, 4'b0000, -1);
    add_vec(0, 1, 4'b0000, -1);
    // fifo 2 only: one pop, then stalled five cycles with A held
    add_vec(0, 0, 4'b0100, 2);
    add_vec(0, 0, 4'b0100, -1);
    add_vec(0, 0, 4'b0100, -1);
    add_vec(0, 0, 4'b0000, -1);
    add_vec(0, 0, 4'b0000, -1);
    add_vec(0, 0, 4'b0000, -1);
    add_vec(0, 1, 4'b0000, 2);
    add_vec(0, 1, 4'b0000, 2);
    add_vec(0, 1, 4'b0000, -1);
    add_vec(0, 1, 4'b0000, -1);
    // priority after last_grant=1: 3, then 1, then 0 before 1
    add_vec(0, 1, 4'b0010, 1);
    add_vec(0, 1, 4'b0000, -1);
    add_vec(0, 1, 4'b1010, 3);
    add_vec(0, 1, 4'b0010, 1);
    add_vec(0, 1, 4'b0001, 0);
    add_vec(0, 1, 4'b0000, 1);
    add_vec(0, 1, 4'b0000, -1);
    add_vec(0, 1, 4'b0000, -1);
    // reset while holding a stalled event; input 0 wins after release
    add_vec(0, 1, 4'b0100, 2);
    add_vec(0, 0, 4'b1111, -1);
    add_vec(1, 0, 4'b0000, -1);
    add_vec(0, 0, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].ready, vecs[i].fill, vecs[i].exp_g);
      if (vecs[i].rst) begin
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
      end
    end

    // random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      logic [3:0] f;
      for (int b = 0; b < NUM_IN; b++) f[b] = ($urandom_range(0, 3) == 0);
      cycle(1'b0, $urandom_range(0, 3) != 0, f, -2);
    end

    // drain everything, bounded
    for (int c = 0; c < 3000 && (total_words() != 0 || ov_m); c++) cycle(1'b0, 1'b1, 4'b0000, -2);
    check("drained", 64'(total_words()), 64'd0);

    // long streaming run for the pop counter
    for (int c = 0; c < LONG_CYCLES; c++) cycle(1'b0, 1'b1, 4'b0001, -2);
    check("stat_end", 64'(stat_pops), 64'(STAT_END));
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 4'b0001, -2);
    check("stat_hold", 64'(stat_pops), 64'(STAT_END));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
